// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
// Owns the PC, issues imem word requests and queues instructions for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int PW = (FIFO_DEPTH > 1) ?
    $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ?
    $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = CW + 1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

  logic [31:0]   pc_q;
  logic [OW-1:0] outst_q;
  logic [OW-1:0] drop_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [TW-1:0] tag_rd_q;
  logic [TW-1:0] tag_wr_q;
  logic          live_q;

  logic [31:0] tag_mem [MAX_OUTSTANDING];
  fq_entry_t   fq_mem [FIFO_DEPTH];

  logic          issue;
  logic          rsp_keep;
  logic          push;
  logic          pop;
  logic [SW-1:0] credit_use;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc[1:0];

  function automatic logic [TW-1:0] tag_inc(
    input logic [TW-1:0] p
  );
    return (p == TW'(MAX_OUTSTANDING - 1)) ?
      '0 : p + TW'(1);
  endfunction

  // Every in-flight request owns a FIFO slot.
  assign credit_use = SW'(outst_q) + SW'(cnt_q);

  assign imem_req_valid = live_q
    && !redirect_valid
    && (outst_q < OW'(MAX_OUTSTANDING))
    && (credit_use < SW'(FIFO_DEPTH));
  assign imem_addr = pc_q;

  assign issue    = imem_req_valid && imem_req_ready;
  assign rsp_keep = imem_rsp_valid && (drop_q == '0);
  assign push     = rsp_keep && !redirect_valid;

  assign id_valid = (cnt_q != '0);
  assign pop      = id_valid && id_ready;

  assign id_inst = id_valid ? fq_mem[rd_q].inst :
                   (live_q ? NOP : 32'h0);
  assign id_pc   = id_valid ? fq_mem[rd_q].pc : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q   <= 1'b0;
      pc_q     <= RESET_PC;
      outst_q  <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
    end else begin
      live_q <= 1'b1;
      // Tags pop on every response, dropped or not.
      if (imem_rsp_valid)
        tag_rd_q <= tag_inc(tag_rd_q);
      if (issue)
        tag_wr_q <= tag_inc(tag_wr_q);
      if (redirect_valid) begin
        pc_q    <= {redirect_pc[31:2], 2'b00};
        outst_q <= outst_q - OW'(imem_rsp_valid);
        drop_q  <= outst_q - OW'(imem_rsp_valid);
        cnt_q   <= '0;
        rd_q    <= '0;
        wr_q    <= '0;
      end else begin
        if (issue)
          pc_q <= pc_q + 32'd4;
        outst_q <= outst_q + OW'(issue)
                   - OW'(imem_rsp_valid);
        if (imem_rsp_valid && (drop_q != '0))
          drop_q <= drop_q - OW'(1);
        if (push)
          wr_q <= wr_q + PW'(1);
        if (pop)
          rd_q <= rd_q + PW'(1);
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue)
      tag_mem[tag_wr_q] <= pc_q;
    if (push)
      fq_mem[wr_q] <= '{inst: imem_rdata,
                        pc:   tag_mem[tag_rd_q]};
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && !pop && (cnt_q == CW'(FIFO_DEPTH))));

  a_drop_le_out: assert property (
    @(posedge clk) disable iff (!rst_n)
    drop_q <= outst_q);

  a_addr_align: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors and scoreboarded
// random traffic for the fetch stage.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic        idr;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
  } vec_t;

  mreq_t       mq[$];
  int          cyc;
  int          last_due;
  int          mem_lat;
  int          total;
  int          bad;
  int          n_id;
  logic [31:0] exp_req;
  logic [31:0] exp_id;
  logic        cap_req;
  logic        cap_id;
  logic [31:0] got_req;
  logic [31:0] got_id;
  logic        hold_v;
  logic [31:0] hold_a;

  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h cycle %0d",
               nm, got, want, cyc);
    end
  endtask

  // Memory presents the head response on the falling edge.
  task automatic cyc_begin();
    @(negedge clk);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rdata     = img(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rdata     = 32'h0;
    end
  endtask

  task automatic cyc_end();
    mreq_t m;
    #1;
    if (hold_v && !redirect_valid) begin
      chk("hold_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("hold_addr", imem_addr, hold_a);
    end
    if (redirect_valid) begin
      chk("redir_gate", {31'b0, imem_req_valid}, 32'd0);
      exp_req = {redirect_pc[31:2], 2'b00};
      exp_id  = {redirect_pc[31:2], 2'b00};
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_addr, exp_req);
        if (cap_req) begin
          got_req = imem_addr;
          cap_req = 1'b0;
        end
        exp_req = exp_req + 32'd4;
        m.addr = imem_addr;
        m.due  = cyc + mem_lat;
        if (m.due <= last_due)
          m.due = last_due + 1;
        last_due = m.due;
        mq.push_back(m);
      end
      if (id_valid && id_ready) begin
        chk("id_pc", id_pc, exp_id);
        chk("id_inst", id_inst, img(exp_id));
        if (cap_id) begin
          got_id = id_pc;
          cap_id = 1'b0;
        end
        exp_id = exp_id + 32'd4;
        n_id++;
      end
    end
    if (imem_rsp_valid)
      void'(mq.pop_front());
    hold_v = imem_req_valid && !imem_req_ready
             && !redirect_valid;
    hold_a = imem_addr;
    cyc++;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    do begin
      cyc_begin();
      imem_req_ready = 1'b0;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      cyc_end();
      k++;
    end while ((mq.size() != 0 || id_valid) && k < 40);
    chk(nm, {31'b0, (mq.size() == 0 && !id_valid)}, 32'd1);
  endtask

  task automatic arm();
    cap_req = 1'b1;
    cap_id  = 1'b1;
    got_req = 32'hffff_ffff;
    got_id  = 32'hffff_ffff;
  endtask

  vec_t vt[9];

  initial begin
    int n0;
    int k;
    total = 0; bad = 0; cyc = 0; n_id = 0;
    last_due = 0; mem_lat = 1;
    exp_req = 32'h0; exp_id = 32'h0;
    cap_req = 1'b0; cap_id = 1'b0;
    got_req = 32'h0; got_id = 32'h0;
    hold_v = 1'b0; hold_a = 32'h0;
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rdata = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b1;

    vt[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vt[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vt[2] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    vt[3] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vt[4] = '{1'b1, 1'b1, 32'h0c, 1'b0, 32'h00};
    vt[5] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h08};
    vt[6] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0c};
    vt[7] = '{1'b1, 1'b1, 32'h14, 1'b0, 32'h00};
    vt[8] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h10};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: sequential fetch, single-cycle memory
    for (int i = 0; i < 9; i++) begin
      cyc_begin();
      id_ready = vt[i].idr;
      cyc_end();
      chk($sformatf("t1_rv%0d", i),
          {31'b0, imem_req_valid}, {31'b0, vt[i].rv});
      if (vt[i].rv)
        chk($sformatf("t1_addr%0d", i), imem_addr, vt[i].addr);
      chk($sformatf("t1_iv%0d", i),
          {31'b0, id_valid}, {31'b0, vt[i].iv});
      if (vt[i].iv) begin
        chk($sformatf("t1_pc%0d", i), id_pc, vt[i].pc);
        chk($sformatf("t1_inst%0d", i), id_inst, img(vt[i].pc));
      end else begin
        chk($sformatf("t1_nop%0d", i), id_inst, NOP);
      end
    end

    // 2: decode stall fills the FIFO and exhausts credits
    for (int i = 0; i < 10; i++) begin
      cyc_begin();
      id_ready = 1'b0;
      cyc_end();
    end
    cyc_begin();
    cyc_end();
    chk("t2_req_blocked", {31'b0, imem_req_valid}, 32'd0);
    chk("t2_id_valid", {31'b0, id_valid}, 32'd1);
    n0 = n_id;
    for (int i = 0; i < 4; i++) begin
      cyc_begin();
      imem_req_ready = 1'b0;
      id_ready = 1'b1;
      cyc_end();
    end
    chk("t2_fifo_entries", 32'(n_id - n0), 32'd2);

    // 3: redirect with two requests in flight
    drain("t3_drain");
    cyc_begin();
    imem_req_ready = 1'b1;
    mem_lat = 4;
    cyc_end();
    cyc_begin();
    cyc_end();
    cyc_begin();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    cyc_end();
    chk("t3_inflight", 32'(mq.size()), 32'd2);
    arm();
    k = 0;
    do begin
      cyc_begin();
      redirect_valid = 1'b0;
      cyc_end();
      k++;
    end while (cap_id && k < 30);
    chk("t3_first_addr", got_req, 32'h0000_0100);
    chk("t3_first_id_pc", got_id, 32'h0000_0100);

    // 4: memory stall holds the request; redirect withdraws it
    drain("t4_drain");
    cyc_begin();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0008;
    cyc_end();
    for (int i = 0; i < 5; i++) begin
      cyc_begin();
      redirect_valid = 1'b0;
      cyc_end();
      chk("t4_stall_valid", {31'b0, imem_req_valid}, 32'd1);
      chk("t4_stall_addr", imem_addr, 32'h0000_0008);
    end
    cyc_begin();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    cyc_end();
    chk("t4_withdraw", {31'b0, imem_req_valid}, 32'd0);
    cyc_begin();
    redirect_valid = 1'b0;
    cyc_end();
    chk("t4_tgt_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t4_tgt_addr", imem_addr, 32'h0000_0200);

    // 5: random latency, backpressure and redirects
    n0 = n_id;
    for (int i = 0; i < 10000; i++) begin
      cyc_begin();
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready = ($urandom_range(0, 3) != 0);
      mem_lat = $urandom_range(1, 4);
      if (redirect_valid)
        redirect_valid = ($urandom_range(0, 1) == 1);
      else
        redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_pc = $urandom & 32'h0003_ffff;
      cyc_end();
    end
    chk("t5_progress", {31'b0, (n_id - n0 > 500)}, 32'd1);

    // 6: asynchronous reset mid-burst
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("t6_id_valid", {31'b0, id_valid}, 32'd0);
    chk("t6_id_inst", id_inst, 32'h0);
    chk("t6_id_pc", id_pc, 32'h0);
    mq.delete();
    last_due = 0;
    hold_v = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    mem_lat = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_req = 32'h0;
    exp_id = 32'h0;
    arm();
    k = 0;
    do begin
      cyc_begin();
      cyc_end();
      k++;
    end while (cap_id && k < 10);
    chk("t6_first_addr", got_req, 32'h0);
    chk("t6_first_id_pc", got_id, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
